// File: rtl/median_window_feeder.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | median_window_feeder: buffers a raster pixel stream in a 4-line ring and     |
// | replays each clamped 3x3 neighbourhood as a 9-cycle DI/DSI burst. rev 1.0    |
// +-----------------------------------------------------------------------------+
module median_window_feeder #(
  parameter int W = 256,
  parameter int H = 256
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic [7:0] PIX_I,
  input  logic       PIX_V,
  output logic       PIX_RDY,
  output logic [7:0] DI,
  output logic       DSI,
  input  logic       DSO,
  output logic       EOF
);

  localparam int XW = (W > 1) ? $clog2(W) : 1;
  localparam int RW = $clog2(H + 3);
  localparam int AW = $clog2(4 * W);

  localparam logic [XW-1:0] X_LAST = XW'(W - 1);
  localparam logic [RW-1:0] R_H    = RW'(H);
  localparam logic [RW-1:0] R_LAST = RW'(H - 1);
  localparam logic [RW-1:0] R_TWO  = RW'(2);
  localparam logic [RW-1:0] R_FOUR = RW'(4);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PREF  = 2'd1,
    S_BURST = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  state_t          state;
  logic [XW-1:0]   xin;
  logic [RW-1:0]   rin;
  logic [XW-1:0]   xout;
  logic [RW-1:0]   yout;
  logic [3:0]      k;

  logic [XW-1:0]   xin_nx;
  logic [RW-1:0]   rin_nx;
  logic [XW-1:0]   xout_nx;
  logic [RW-1:0]   yout_nx;
  logic            accept;
  logic            advance;
  logic            last_win;

  logic [XW-1:0]   x_m;
  logic [XW-1:0]   x_p;
  logic [RW-1:0]   y_m;
  logic [RW-1:0]   y_p;
  logic [XW-1:0]   rx;
  logic [RW-1:0]   ry;
  logic [3:0]      rd_idx;
  logic            rd_en;
  logic [AW-1:0]   rd_addr;
  logic [AW-1:0]   wr_addr;

  logic [7:0]      mem [0:4*W-1];
  logic [7:0]      rd_data;

  // Window needs row min(y+1, H-1) complete, i.e. rin >= min(y+2, H).
  function automatic logic win_ready(input logic [RW-1:0] r, input logic [RW-1:0] y);
    logic [RW-1:0] need;
    need = ((y + R_TWO) > R_H) ? R_H : (y + R_TWO);
    return r >= need;
  endfunction

  always_comb begin
    accept   = PIX_V && PIX_RDY;
    advance  = (state == S_WAIT) && DSO;
    last_win = (xout == X_LAST) && (yout == R_LAST);
    xin_nx   = xin;
    rin_nx   = rin;
    xout_nx  = xout;
    yout_nx  = yout;
    if (accept) begin
      if (xin == X_LAST) begin
        xin_nx = '0;
        rin_nx = rin + RW'(1);
      end else begin
        xin_nx = xin + XW'(1);
      end
    end
    if (advance) begin
      if (last_win) begin
        rin_nx  = '0;
        xout_nx = '0;
        yout_nx = '0;
      end else if (xout == X_LAST) begin
        xout_nx = '0;
        yout_nx = yout + RW'(1);
      end else begin
        xout_nx = xout + XW'(1);
      end
    end
  end

  always_comb begin
    x_m    = (xout == '0) ? '0 : (xout - XW'(1));
    x_p    = (xout == X_LAST) ? xout : (xout + XW'(1));
    y_m    = (yout == '0) ? '0 : (yout - RW'(1));
    y_p    = (yout == R_LAST) ? yout : (yout + RW'(1));
    rd_idx = (state == S_BURST) ? (k + 4'd1) : 4'd0;
    rd_en  = (state == S_PREF) || ((state == S_BURST) && (k != 4'd8));
    case (rd_idx)
      4'd0, 4'd3, 4'd6: rx = x_m;
      4'd1, 4'd4, 4'd7: rx = xout;
      default:          rx = x_p;
    endcase
    case (rd_idx)
      4'd0, 4'd1, 4'd2: ry = y_m;
      4'd3, 4'd4, 4'd5: ry = yout;
      default:          ry = y_p;
    endcase
    rd_addr = AW'(ry % R_FOUR) * AW'(W) + AW'(rx);
    wr_addr = AW'(rin % R_FOUR) * AW'(W) + AW'(xin);
  end

  always_ff @(posedge CLK) begin
    if (accept) begin
      mem[wr_addr] <= PIX_I;
    end
  end

  // Read register is reset so DI never shows X before the first burst.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

  assign DI = rd_data;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= S_IDLE;
      xin     <= '0;
      rin     <= '0;
      xout    <= '0;
      yout    <= '0;
      k       <= '0;
      PIX_RDY <= 1'b0;
      DSI     <= 1'b0;
      EOF     <= 1'b0;
    end else begin
      xin     <= xin_nx;
      rin     <= rin_nx;
      xout    <= xout_nx;
      yout    <= yout_nx;
      PIX_RDY <= (rin_nx < R_H) && (rin_nx <= (yout_nx + R_TWO));
      EOF     <= advance && last_win;
      case (state)
        S_IDLE: begin
          if (win_ready(rin, yout)) begin
            state <= S_PREF;
          end
        end
        S_PREF: begin
          state <= S_BURST;
          DSI   <= 1'b1;
          k     <= 4'd0;
        end
        S_BURST: begin
          if (k == 4'd8) begin
            state <= S_WAIT;
            DSI   <= 1'b0;
          end else begin
            k <= k + 4'd1;
          end
        end
        S_WAIT: begin
          if (DSO) begin
            if (last_win) begin
              state <= S_IDLE;
            end else if (win_ready(rin_nx, yout_nx)) begin
              state <= S_PREF;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
